// File: rtl/pwm_pkg.sv
// Shared constants and pin-mode decoding for the PWM output block.
package pwm_pkg;

    localparam int unsigned               PWM_CNT_W    = 8;
    localparam logic [PWM_CNT_W-1:0]      DUTY_FULL_ON = 8'hFF;
    localparam int unsigned               PWM_STEPS    = 256;

    typedef enum logic [1:0] {
        PIN_LOW  = 2'd0,
        PIN_HIGH = 2'd1,
        PIN_PWM  = 2'd2
    } pin_mode_e;

    // Output enable dominates the PWM select.
    function automatic pin_mode_e pin_mode(input logic en_out, input logic en_pwm);
        if (!en_out) begin
            return PIN_LOW;
        end
        if (!en_pwm) begin
            return PIN_HIGH;
        end
        return PIN_PWM;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Free-running divider: tick is high during the last of every PRESCALE clk cycles.
module pwm_prescaler #(
    parameter int unsigned PRESCALE = 3000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned      CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] r_prescale_cnt;

    // With PRESCALE=1 the counter sits at zero and tick is permanently high.
    assign tick = (r_prescale_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prescale_cnt <= '0;
        end else if (tick) begin
            r_prescale_cnt <= '0;
        end else begin
            r_prescale_cnt <= r_prescale_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pwm_generator.sv
// Drives 16 pins as low, high or a shared PWM waveform; duty is shadowed to period boundaries.
module pwm_generator
    import pwm_pkg::*;
#(
    parameter int unsigned PRESCALE = 3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    logic                 w_tick;
    logic                 w_period_end;
    logic                 w_pwm_level;
    logic [15:0]          w_en_out;
    logic [15:0]          w_en_pwm;
    logic [15:0]          w_out_next;

    logic [PWM_CNT_W-1:0] r_pwm_cnt;
    logic [PWM_CNT_W-1:0] r_duty_shadow;
    logic [15:0]          r_out;
    logic                 r_period_start;

    pwm_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    assign w_en_out     = {en_reg_out_15_8, en_reg_out_7_0};
    assign w_en_pwm     = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign w_period_end = w_tick && (r_pwm_cnt == PWM_CNT_W'(PWM_STEPS - 1));

    always_comb begin
        w_pwm_level = (r_duty_shadow == DUTY_FULL_ON) || (r_pwm_cnt < r_duty_shadow);
    end

    always_comb begin
        w_out_next = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            case (pin_mode(w_en_out[i], w_en_pwm[i]))
                PIN_LOW:  w_out_next[i] = 1'b0;
                PIN_HIGH: w_out_next[i] = 1'b1;
                PIN_PWM:  w_out_next[i] = w_pwm_level;
                default:  w_out_next[i] = 1'b0;
            endcase
        end
    end

    // Shadow and period_start update on the same edge as the 255->0 wrap,
    // so the new duty is visible together with pwm_cnt==0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt      <= '0;
            r_duty_shadow  <= '0;
            r_out          <= '0;
            r_period_start <= 1'b0;
        end else begin
            if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + PWM_CNT_W'(1);
            end
            if (w_period_end) begin
                r_duty_shadow <= pwm_duty_cycle;
            end
            r_out          <= w_out_next;
            r_period_start <= w_period_end;
        end
    end

    assign out          = r_out;
    assign period_start = r_period_start;

endmodule

// File: tb/tb_pwm_generator.sv
// Scoreboard bench for pwm_generator: per-cycle reference model plus measured high times.
module tb_pwm_generator;

    localparam int unsigned P   = 4;
    localparam int unsigned PER = 256 * P;

    typedef struct {
        logic [15:0] out;
        logic        ps;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;
    logic        period_start;

    pwm_generator #(
        .PRESCALE (P)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .out             (out),
        .period_start    (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus variables, applied to the DUT at each negedge by step().
    logic [15:0] s_en_out;
    logic [15:0] s_en_pwm;
    logic [7:0]  s_duty;
    logic        s_rst;

    // Reference model: elapsed clk edges since reset release and the latched duty.
    int unsigned m_edges;
    logic [7:0]  m_shadow;
    int unsigned m_periods;

    exp_t sb[$];
    int   hi_times[$];
    int   hi_cnt;
    bit   started;
    int   n_cmp;
    int   n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int unsigned model_cnt();
        return (m_edges / P) % 256;
    endfunction

    task automatic step();
        int unsigned cnt;
        logic        lvl;
        exp_t        e;
        @(negedge clk);
        rst_n           = s_rst;
        en_reg_out_7_0  = s_en_out[7:0];
        en_reg_out_15_8 = s_en_out[15:8];
        en_reg_pwm_7_0  = s_en_pwm[7:0];
        en_reg_pwm_15_8 = s_en_pwm[15:8];
        pwm_duty_cycle  = s_duty;
        if (!s_rst) begin
            m_edges  = 0;
            m_shadow = 8'h00;
            e.out    = 16'h0000;
            e.ps     = 1'b0;
        end else begin
            cnt     = model_cnt();
            lvl     = (m_shadow == 8'hFF) ? 1'b1 : (cnt < int'(m_shadow));
            e.out   = s_en_out & (~s_en_pwm | {16{lvl}});
            m_edges = m_edges + 1;
            e.ps    = (m_edges % PER) == 0;
            if (e.ps) begin
                m_shadow  = s_duty;
                m_periods = m_periods + 1;
            end
        end
        sb.push_back(e);
        started = 1'b1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Run until n more period starts have been issued, then one extra cycle so the monitor sees the last.
    task automatic run_periods(input int n);
        int unsigned target;
        int          budget;
        target = m_periods + n;
        budget = n * PER + 1100;
        while (m_periods < target && budget > 0) begin
            step();
            budget--;
        end
        if (m_periods < target) check("run_periods_timeout", 0, 1);
        step();
    endtask

    task automatic run_to_cnt(input int unsigned c);
        int budget;
        budget = PER + 100;
        while (model_cnt() != c && budget > 0) begin
            step();
            budget--;
        end
        if (model_cnt() != c) check("run_to_cnt_timeout", 0, 1);
    endtask

    task automatic check_hi(input string name, input int back, input int req);
        if (hi_times.size() < back) begin
            check({name, "_missing"}, hi_times.size(), back);
        end else begin
            check(name, hi_times[hi_times.size() - back], req);
        end
    endtask

    // Monitor: pop one expectation per clk and measure out[0] high time per period.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                if (started) check("sb_underflow", 0, 1);
            end else begin
                e = sb.pop_front();
                check("out", out, e.out);
                check("period_start", period_start, e.ps);
            end
            if (!rst_n) begin
                hi_cnt = 0;
            end else begin
                hi_cnt += int'(out[0]);
                if (period_start) begin
                    hi_times.push_back(hi_cnt);
                    hi_cnt = 0;
                end
            end
        end
    end

    initial begin
        int gap;
        n_cmp     = 0;
        n_fail    = 0;
        started   = 1'b0;
        hi_cnt    = 0;
        m_edges   = 0;
        m_shadow  = 8'h00;
        m_periods = 0;
        s_rst     = 1'b0;
        s_en_out  = '0;
        s_en_pwm  = '0;
        s_duty    = 8'h00;
        rst_n           = 1'b0;
        en_reg_out_7_0  = '0;
        en_reg_out_15_8 = '0;
        en_reg_pwm_7_0  = '0;
        en_reg_pwm_15_8 = '0;
        pwm_duty_cycle  = '0;

        run(3);
        s_rst = 1'b1;
        run(2048);

        s_en_out = 16'h00FF;
        run(10);

        s_en_out = 16'hFFFF;
        s_en_pwm = 16'h0001;
        s_duty   = 8'h80;
        hi_times.delete();
        run_periods(3);
        check_hi("hi_duty80_a", 2, 512);
        check_hi("hi_duty80_b", 1, 512);

        s_duty = 8'h00;
        run_periods(2);
        check_hi("hi_duty00", 1, 0);

        s_duty = 8'hFF;
        run_periods(4);
        check_hi("hi_dutyFF_a", 3, 1024);
        check_hi("hi_dutyFF_b", 2, 1024);
        check_hi("hi_dutyFF_c", 1, 1024);

        s_duty = 8'h01;
        run_periods(2);
        check_hi("hi_duty01", 1, 4);

        s_duty = 8'h40;
        run_periods(1);
        run_to_cnt(100);
        s_duty = 8'hC0;
        run_periods(2);
        check_hi("hi_mid_change_old", 2, 256);
        check_hi("hi_mid_change_new", 1, 768);

        for (int k = 0; k < 12; k++) begin
            s_en_out = 16'($urandom);
            s_en_pwm = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       s_duty = 8'h00;
                1:       s_duty = 8'hFF;
                default: s_duty = 8'($urandom);
            endcase
            gap = int'($urandom_range(1, 700));
            run(gap);
        end

        s_en_out = 16'hFFFF;
        s_en_pwm = 16'h0001;
        s_duty   = 8'hFF;
        run_periods(1);
        run_to_cnt(200);
        @(posedge clk);
        #3;
        check("pre_rst_out0", 32'(out[0]), 1);
        s_rst = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("async_rst_out", out, 0);
        check("async_rst_ps", period_start, 0);
        run(5);
        hi_times.delete();
        s_rst = 1'b1;
        run_periods(2);
        check_hi("hi_after_rst_shadow0", 2, 0);
        check_hi("hi_after_rst_full", 1, 1024);

        run(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
